// File: rtl/jt12_syn_wrdec_if.sv
// jt12_syn_wrdec_if
//   Bundles the synthesizer-side write bus: the synchronized CPU write
//   request (syn_write/syn_addr/syn_din), the busy line back to the CPU,
//   the register-file write strobe outputs and the queue overflow flag.
//
// Modports:
//   master - CPU/test side: drives syn_write, syn_addr, syn_din, ovf_clr;
//            observes syn_busy, wr_stb, wr_part, wr_reg, wr_data, ovf.
//   slave  - decoder side (jt12_syn_wrdec): the mirror image.
interface jt12_syn_wrdec_if;
  logic       syn_write;
  logic [1:0] syn_addr;
  logic [7:0] syn_din;
  logic       syn_busy;
  logic       wr_stb;
  logic       wr_part;
  logic [7:0] wr_reg;
  logic [7:0] wr_data;
  logic       ovf;
  logic       ovf_clr;

  modport master (
    output syn_write, syn_addr, syn_din, ovf_clr,
    input  syn_busy, wr_stb, wr_part, wr_reg, wr_data, ovf
  );

  modport slave (
    input  syn_write, syn_addr, syn_din, ovf_clr,
    output syn_busy, wr_stb, wr_part, wr_reg, wr_data, ovf
  );
endinterface

// File: rtl/jt12_syn_wrdec.sv
// jt12_syn_wrdec
//   Synthesizer-side write decoder. Every level change on syn_write is one
//   CPU write; the accompanying address/data bytes are captured and turned
//   into single-cycle register-file write strobes. Address-port writes only
//   update the per-part register selector, data-port writes strobe
//   (part, selected register, value). syn_busy is held high for
//   BUSY_CYCLES clocks per processed write.
//
// Parameters:
//   BUSY_CYCLES - clocks busy stays high per write, strobe cycle included (2..255)
//   FIFO_DEPTH  - write queue depth, power of two 2..16 (JT12_WRFIFO_EN only)
//
// Ports:
//   clk   - synthesizer clock, posedge
//   rst_n - asynchronous active-low reset
//   bus   - jt12_syn_wrdec_if.slave: syn_write/syn_addr/syn_din/ovf_clr in,
//           syn_busy/wr_stb/wr_part/wr_reg/wr_data/ovf out
//
// Optional feature macro: JT12_WRFIFO_EN
//   defined   - captured writes queue in a FIFO_DEPTH-entry FIFO; a write
//               arriving on a full queue is dropped and sets sticky ovf.
//   undefined - single holding register, latest write wins; ovf tied to 0.
module jt12_syn_wrdec #(
  parameter int BUSY_CYCLES = 32,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  jt12_syn_wrdec_if.slave bus
);

  typedef enum logic [1:0] {IDLE, APPLY, HOLD} state_t;

  // The APPLY cycle is the first busy clock, so HOLD covers the remaining
  // BUSY_CYCLES-1 clocks: counting down from BUSY_CYCLES-2 to 0 inclusive.
  localparam logic [7:0] HOLD_LOAD = 8'(BUSY_CYCLES - 2);

  logic       sync1, sync2, hist;
  logic [2:0] arm_cnt;
  logic       armed, edge_ok;
  logic [9:0] new_ent;
  logic       q_pending;
  logic       take;
  logic [9:0] take_ent;
  logic       stb_next;

  state_t     state, state_next;
  logic [7:0] hold_cnt, hold_next;

  logic       busy_r, stb_r, part_r;
  logic [7:0] reg_r, data_r;
  logic [7:0] sel [2];

  // Two-flop synchronizer plus history flop. History always follows sync2,
  // so whatever level syn_write had through reset has settled before the
  // arm counter lets edges through.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      hist    <= 1'b0;
      arm_cnt <= 3'd0;
    end else begin
      sync1 <= bus.syn_write;
      sync2 <= sync1;
      hist  <= sync2;
      if (arm_cnt != 3'd4)
        arm_cnt <= arm_cnt + 3'd1;
    end
  end

  assign armed   = (arm_cnt == 3'd4);
  assign edge_ok = armed & (sync2 ^ hist);
  // Entry layout: {part, port, byte}
  assign new_ent = {bus.syn_addr[1], bus.syn_addr[0], bus.syn_din};

`ifdef JT12_WRFIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [9:0]  mem [FIFO_DEPTH];
  logic [AW:0] rd_ptr, wr_ptr;
  logic        empty, full, pop, push, drop;
  logic        ovf_r;

  assign empty = (rd_ptr == wr_ptr);
  assign full  = (rd_ptr[AW] != wr_ptr[AW]) && (rd_ptr[AW-1:0] == wr_ptr[AW-1:0]);
  // Taking with an empty queue means the edge is being consumed directly
  // (edge coinciding with the end of HOLD), so it bypasses the storage.
  assign pop       = take & ~empty;
  assign push      = edge_ok & ~(take & empty) & (~full | pop);
  assign drop      = edge_ok & full & ~pop;
  assign q_pending = ~empty;
  assign take_ent  = empty ? new_ent : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr[AW-1:0]] <= new_ent;
  end

  // Overflow set wins over a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      ovf_r  <= 1'b0;
    end else begin
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (drop)
        ovf_r <= 1'b1;
      else if (bus.ovf_clr)
        ovf_r <= 1'b0;
    end
  end

  assign bus.ovf = ovf_r;
`else
  logic [9:0] hold_ent;
  logic       hold_vld;
  logic       unused_cfg;

  // A fresh edge always supersedes a not-yet-applied entry.
  assign q_pending = hold_vld;
  assign take_ent  = edge_ok ? new_ent : hold_ent;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_ent <= 10'd0;
      hold_vld <= 1'b0;
    end else if (take) begin
      hold_vld <= 1'b0;
    end else if (edge_ok) begin
      hold_ent <= new_ent;
      hold_vld <= 1'b1;
    end
  end

  assign bus.ovf    = 1'b0;
  assign unused_cfg = bus.ovf_clr ^ FIFO_DEPTH[0];
`endif

  // Next-state logic. IDLE only acts on stored entries; at the end of HOLD a
  // same-cycle edge is also accepted so back-to-back writes leave no gap.
  always_comb begin
    state_next = state;
    hold_next  = hold_cnt;
    take       = 1'b0;
    case (state)
      IDLE: begin
        if (q_pending) begin
          take       = 1'b1;
          state_next = APPLY;
        end
      end
      APPLY: begin
        hold_next  = HOLD_LOAD;
        state_next = HOLD;
      end
      HOLD: begin
        if (hold_cnt != 8'd0) begin
          hold_next = hold_cnt - 8'd1;
        end else if (q_pending | edge_ok) begin
          take       = 1'b1;
          state_next = APPLY;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    stb_next = take & take_ent[8];
  end

  // The APPLY actions are registered on the transition into APPLY, so the
  // strobe and busy are visible during the APPLY cycle itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      hold_cnt <= 8'd0;
      busy_r   <= 1'b0;
      stb_r    <= 1'b0;
      part_r   <= 1'b0;
      reg_r    <= 8'd0;
      data_r   <= 8'd0;
      sel[0]   <= 8'd0;
      sel[1]   <= 8'd0;
    end else begin
      state    <= state_next;
      hold_cnt <= hold_next;
      busy_r   <= (state_next != IDLE) | q_pending;
      stb_r    <= stb_next;
      if (take) begin
        if (take_ent[8]) begin
          part_r <= take_ent[9];
          reg_r  <= sel[take_ent[9]];
          data_r <= take_ent[7:0];
        end else begin
          sel[take_ent[9]] <= take_ent[7:0];
        end
      end
    end
  end

  assign bus.syn_busy = busy_r;
  assign bus.wr_stb   = stb_r;
  assign bus.wr_part  = part_r;
  assign bus.wr_reg   = reg_r;
  assign bus.wr_data  = data_r;

endmodule

// File: tb/tb_jt12_syn_wrdec.sv
// tb_jt12_syn_wrdec
//   Directed bench for jt12_syn_wrdec with BUSY_CYCLES = 8. Writes are
//   issued on a falling clock edge; "k" counts falling edges after the
//   write, so the strobe of an isolated write is expected at k = 4 and busy
//   is high for k = 4 .. 3+BC. Outputs are sampled on falling edges.
module tb_jt12_syn_wrdec;
  localparam int BC = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   vectors     = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  jt12_syn_wrdec_if bus ();

  jt12_syn_wrdec #(.BUSY_CYCLES(BC), .FIFO_DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic cpu_write(input logic [1:0] a, input logic [7:0] d);
    bus.syn_addr  = a;
    bus.syn_din   = d;
    bus.syn_write = ~bus.syn_write;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n       = 1'b0;
    bus.ovf_clr = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset();
    bus.syn_write = 1'b1;
    bus.syn_addr  = 2'd0;
    bus.syn_din   = 8'd0;
    bus.ovf_clr   = 1'b0;
    rst_n         = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({bus.wr_stb, bus.wr_part, bus.wr_reg, bus.wr_data, bus.syn_busy, bus.ovf} !== 20'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_values got stb=%b part=%b reg=%h data=%h busy=%b ovf=%b want all 0",
               bus.wr_stb, bus.wr_part, bus.wr_reg, bus.wr_data, bus.syn_busy, bus.ovf);
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      vectors++;
      if ({bus.wr_stb, bus.syn_busy} !== 2'b00) begin
        miscompares++;
        $display("[TB] FAIL reset_release k=%0d got stb/busy=%b%b want 00", k, bus.wr_stb, bus.syn_busy);
      end
    end
  endtask

  task automatic test_addr_data();
    logic [1:0] ta [2] = '{2'd0, 2'd1};
    logic [7:0] td [2] = '{8'h28, 8'hF1};
    logic       ts [2] = '{1'b0, 1'b1};
    logic       es, eb;
    for (int i = 0; i < 2; i++) begin
      cpu_write(ta[i], td[i]);
      for (int k = 1; k <= BC + 4; k++) begin
        @(negedge clk);
        es = ts[i] && (k == 4);
        eb = (k >= 4) && (k <= BC + 3);
        vectors++;
        if ({bus.wr_stb, bus.syn_busy} !== {es, eb}) begin
          miscompares++;
          $display("[TB] FAIL addr_data w%0d k=%0d got stb/busy=%b%b want %b%b", i, k, bus.wr_stb, bus.syn_busy, es, eb);
        end
        if (es) begin
          vectors++;
          if ({bus.wr_part, bus.wr_reg, bus.wr_data} !== {1'b0, 8'h28, 8'hF1}) begin
            miscompares++;
            $display("[TB] FAIL addr_data_fields got %b/%h/%h want 0/28/f1", bus.wr_part, bus.wr_reg, bus.wr_data);
          end
        end
      end
    end
    vectors++;
    if ({bus.wr_part, bus.wr_reg, bus.wr_data} !== {1'b0, 8'h28, 8'hF1}) begin
      miscompares++;
      $display("[TB] FAIL fields_hold got %b/%h/%h want 0/28/f1", bus.wr_part, bus.wr_reg, bus.wr_data);
    end
  endtask

  task automatic test_part2();
    logic [1:0] ta [3] = '{2'd2, 2'd3, 2'd1};
    logic [7:0] td [3] = '{8'h30, 8'h7F, 8'h01};
    logic       ts [3] = '{1'b0, 1'b1, 1'b1};
    logic       tp [3] = '{1'b0, 1'b1, 1'b0};
    logic [7:0] tr [3] = '{8'h00, 8'h30, 8'h00};
    logic       es;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cpu_write(ta[i], td[i]);
      for (int k = 1; k <= BC + 4; k++) begin
        @(negedge clk);
        es = ts[i] && (k == 4);
        vectors++;
        if (bus.wr_stb !== es) begin
          miscompares++;
          $display("[TB] FAIL part2 w%0d k=%0d got stb=%b want %b", i, k, bus.wr_stb, es);
        end
        if (es) begin
          vectors++;
          if ({bus.wr_part, bus.wr_reg, bus.wr_data} !== {tp[i], tr[i], td[i]}) begin
            miscompares++;
            $display("[TB] FAIL part2_fields w%0d got %b/%h/%h want %b/%h/%h", i,
                     bus.wr_part, bus.wr_reg, bus.wr_data, tp[i], tr[i], td[i]);
          end
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic       es, eb;
    logic [7:0] ed;
    do_reset();
    cpu_write(2'd1, 8'hA1);
    for (int k = 1; k <= 2 * BC + 6; k++) begin
      @(negedge clk);
      es = (k == 4) || (k == 4 + BC);
      eb = (k >= 4) && (k <= 3 + 2 * BC);
      vectors++;
      if ({bus.wr_stb, bus.syn_busy} !== {es, eb}) begin
        miscompares++;
        $display("[TB] FAIL b2b k=%0d got stb/busy=%b%b want %b%b", k, bus.wr_stb, bus.syn_busy, es, eb);
      end
      if (es) begin
        ed = (k == 4) ? 8'hA1 : 8'hA2;
        vectors++;
        if (bus.wr_data !== ed) begin
          miscompares++;
          $display("[TB] FAIL b2b_data k=%0d got %h want %h", k, bus.wr_data, ed);
        end
      end
      if (k == 4) cpu_write(2'd1, 8'hA2);
    end
  endtask

  task automatic test_hold_edge();
    logic       es, eb;
    logic [7:0] ed;
    do_reset();
    cpu_write(2'd1, 8'hC1);
    for (int k = 1; k <= 2 * BC + 6; k++) begin
      @(negedge clk);
      es = (k == 4) || (k == 4 + BC);
      eb = (k >= 4) && (k <= 3 + 2 * BC);
      vectors++;
      if ({bus.wr_stb, bus.syn_busy} !== {es, eb}) begin
        miscompares++;
        $display("[TB] FAIL hold_edge k=%0d got stb/busy=%b%b want %b%b", k, bus.wr_stb, bus.syn_busy, es, eb);
      end
      if (es) begin
        ed = (k == 4) ? 8'hC1 : 8'hC2;
        vectors++;
        if (bus.wr_data !== ed) begin
          miscompares++;
          $display("[TB] FAIL hold_edge_data k=%0d got %h want %h", k, bus.wr_data, ed);
        end
      end
      if (k == BC + 1) cpu_write(2'd1, 8'hC2);
    end
  endtask

`ifndef JT12_WRFIFO_EN
  task automatic test_latest_wins();
    logic       es, eb;
    logic [7:0] ed;
    do_reset();
    cpu_write(2'd1, 8'hB1);
    for (int k = 1; k <= 2 * BC + 6; k++) begin
      @(negedge clk);
      es = (k == 4) || (k == 4 + BC);
      eb = (k >= 4) && (k <= 3 + 2 * BC);
      vectors++;
      if ({bus.wr_stb, bus.syn_busy, bus.ovf} !== {es, eb, 1'b0}) begin
        miscompares++;
        $display("[TB] FAIL latest k=%0d got stb/busy/ovf=%b%b%b want %b%b0", k,
                 bus.wr_stb, bus.syn_busy, bus.ovf, es, eb);
      end
      if (es) begin
        ed = (k == 4) ? 8'hB1 : 8'hB3;
        vectors++;
        if (bus.wr_data !== ed) begin
          miscompares++;
          $display("[TB] FAIL latest_data k=%0d got %h want %h", k, bus.wr_data, ed);
        end
      end
      if (k == 4) cpu_write(2'd1, 8'hB2);
      if (k == 6) cpu_write(2'd1, 8'hB3);
    end
  endtask
`else
  task automatic test_fifo_ovf();
    logic       es, eo;
    logic [7:0] ed;
    do_reset();
    cpu_write(2'd0, 8'h40);
    repeat (BC + 4) @(negedge clk);
    cpu_write(2'd1, 8'h50);
    for (int k = 1; k <= 56; k++) begin
      @(negedge clk);
      es = (k >= 4) && ((k - 4) % 8 == 0) && ((k - 4) / 8 <= 5);
      eo = (k >= 15);
      vectors++;
      if ({bus.wr_stb, bus.ovf} !== {es, eo}) begin
        miscompares++;
        $display("[TB] FAIL fifo k=%0d got stb/ovf=%b%b want %b%b", k, bus.wr_stb, bus.ovf, es, eo);
      end
      if (es) begin
        ed = 8'h50 + 8'((k - 4) / 8);
        vectors++;
        if ({bus.wr_reg, bus.wr_data} !== {8'h40, ed}) begin
          miscompares++;
          $display("[TB] FAIL fifo_data k=%0d got %h/%h want 40/%h", k, bus.wr_reg, bus.wr_data, ed);
        end
      end
      if ((k <= 12) && (k % 2 == 0)) cpu_write(2'd1, 8'h50 + 8'(k / 2));
    end
    bus.ovf_clr = 1'b1;
    @(negedge clk);
    bus.ovf_clr = 1'b0;
    vectors++;
    if ({bus.ovf, bus.syn_busy} !== 2'b00) begin
      miscompares++;
      $display("[TB] FAIL ovf_clr got ovf/busy=%b%b want 00", bus.ovf, bus.syn_busy);
    end
  endtask
`endif

  task automatic test_reset_mid();
    do_reset();
    cpu_write(2'd1, 8'hE1);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 4) begin
        vectors++;
        if ({bus.wr_stb, bus.wr_data} !== {1'b1, 8'hE1}) begin
          miscompares++;
          $display("[TB] FAIL mid_first got stb=%b data=%h want 1/e1", bus.wr_stb, bus.wr_data);
        end
        cpu_write(2'd1, 8'hE2);
      end
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({bus.syn_busy, bus.wr_data} !== {1'b0, 8'h00}) begin
      miscompares++;
      $display("[TB] FAIL mid_async got busy=%b data=%h want 0/00", bus.syn_busy, bus.wr_data);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 3 * BC; k++) begin
      @(negedge clk);
      vectors++;
      if ({bus.wr_stb, bus.syn_busy} !== 2'b00) begin
        miscompares++;
        $display("[TB] FAIL mid_after k=%0d got stb/busy=%b%b want 00", k, bus.wr_stb, bus.syn_busy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_addr_data();
    test_part2();
    test_back_to_back();
    test_hold_edge();
`ifndef JT12_WRFIFO_EN
    test_latest_wins();
`else
    test_fifo_ovf();
`endif
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
